// File: rtl/mem_wb_stage.sv
// Data-memory access stage with a wait-state sequencer and the MEM/WB pipeline register.
// Holds the upstream pipeline while a load/store is in flight, then registers the write-back value.
module mem_wb_stage #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  control_signals_M,
    input  logic [1:0]  control_signals_WB,
    input  logic [31:0] result,
    input  logic [31:0] write_data,
    input  logic [4:0]  RegDest,
    output logic        stall,
    output logic [1:0]  control_signals_WB_out,
    output logic [31:0] read_data_out,
    output logic [31:0] result_out,
    output logic [4:0]  RegDestOut,
    output logic [31:0] write_value,
    output logic        misalign
);

    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_stall;

    logic [31:0]       r_mem [DEPTH];
    logic [1:0]        r_wb_p0;
    logic [31:0]       r_rdata_p0;
    logic [31:0]       r_result_p0;
    logic [4:0]        r_rd_p0;
    logic              r_misalign_p0;

    logic              w_memread;
    logic              w_memwrite;
    logic              w_memop;
    logic              w_misaligned;
    logic [ADDR_W-1:0] w_idx;
    logic              w_unused;

    assign w_memread    = control_signals_M[1];
    assign w_memwrite   = control_signals_M[0];
    assign w_memop      = w_memread | w_memwrite;
    assign w_misaligned = w_memop & (result[1:0] != 2'b00);
    assign w_idx        = result[ADDR_W+1:2];
    assign w_unused     = ^{control_signals_M[3:2], result[31:ADDR_W+2]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The op type is only looked at in IDLE; ACCESS is driven purely by the counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_memop && (WAIT_STATES > 0)) begin
                    w_stall     = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt != '0) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Stall is masked while reset is held so upstream is never frozen during reset.
    assign stall = w_stall & rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!w_stall && w_memwrite && !w_misaligned) begin
            r_mem[w_idx] <= write_data;
        end
    end

    // MEM/WB register: completion edges load the op, stall edges insert a bubble.
    always_ff @(posedge clk) begin
        if (!rst || w_stall) begin
            r_wb_p0       <= '0;
            r_rdata_p0    <= '0;
            r_result_p0   <= '0;
            r_rd_p0       <= '0;
            r_misalign_p0 <= 1'b0;
        end else begin
            r_wb_p0       <= {control_signals_WB[1] & ~w_misaligned, control_signals_WB[0]};
            r_rdata_p0    <= (w_memread && !w_memwrite && !w_misaligned) ? r_mem[w_idx] : '0;
            r_result_p0   <= result;
            r_rd_p0       <= RegDest;
            r_misalign_p0 <= w_misaligned;
        end
    end

    assign control_signals_WB_out = r_wb_p0;
    assign read_data_out          = r_rdata_p0;
    assign result_out             = r_result_p0;
    assign RegDestOut             = r_rd_p0;
    assign misalign               = r_misalign_p0;
    assign write_value            = r_wb_p0[0] ? r_rdata_p0 : r_result_p0;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;

    logic [3:0]  c_M;
    logic [1:0]  c_WB;
    logic [31:0] c_res;
    logic [31:0] c_wd;
    logic [4:0]  c_rd;
    logic        stall;
    logic [1:0]  wb_out;
    logic [31:0] rdata;
    logic [31:0] res_out;
    logic [4:0]  rd_out;
    logic [31:0] wval;
    logic        mis;

    logic [3:0]  z_M;
    logic [1:0]  z_WB;
    logic [31:0] z_res;
    logic [31:0] z_wd;
    logic [4:0]  z_rd;
    logic        z_stall;
    logic [1:0]  z_wb_out;
    logic [31:0] z_rdata;
    logic [31:0] z_res_out;
    logic [4:0]  z_rd_out;
    logic [31:0] z_wval;
    logic        z_mis;

    int n_cmp = 0;
    int n_err = 0;

    mem_wb_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst),
        .control_signals_M(c_M), .control_signals_WB(c_WB),
        .result(c_res), .write_data(c_wd), .RegDest(c_rd),
        .stall(stall), .control_signals_WB_out(wb_out),
        .read_data_out(rdata), .result_out(res_out), .RegDestOut(rd_out),
        .write_value(wval), .misalign(mis)
    );

    mem_wb_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .control_signals_M(z_M), .control_signals_WB(z_WB),
        .result(z_res), .write_data(z_wd), .RegDest(z_rd),
        .stall(z_stall), .control_signals_WB_out(z_wb_out),
        .read_data_out(z_rdata), .result_out(z_res_out), .RegDestOut(z_rd_out),
        .write_value(z_wval), .misalign(z_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nop();
        c_M = 4'h0; c_WB = 2'b00; c_res = 32'h0; c_wd = 32'h0; c_rd = 5'd0;
    endtask

    // Drives one op and waits for its completion edge; returns the number of stall cycles seen.
    task automatic do_op(input logic [3:0] m, input logic [1:0] wb, input logic [31:0] res,
                         input logic [31:0] wd, input logic [4:0] rd, output int n);
        c_M = m; c_WB = wb; c_res = res; c_wd = wd; c_rd = rd;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (n >= 10) begin
            n_err++;
            $display("FAIL op_timeout: stall still high after %0d cycles, required release within 10", n);
        end
        @(posedge clk); #1;
        nop();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        nop();
        z_M = 4'h0; z_WB = 2'b00; z_res = 32'h0; z_wd = 32'h0; z_rd = 5'd0;
        @(posedge clk); @(posedge clk); #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (wb_out !== 2'b00) begin n_err++; $display("FAIL reset_wb: got %b want 00", wb_out); end
        n_cmp++; if (wval !== 32'h0) begin n_err++; $display("FAIL reset_wval: got %h want 0", wval); end
        n_cmp++; if (rd_out !== 5'd0) begin n_err++; $display("FAIL reset_rd: got %0d want 0", rd_out); end
        n_cmp++; if (mis !== 1'b0) begin n_err++; $display("FAIL reset_mis: got %b want 0", mis); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL idle_stall: got %b want 0", stall); end
        n_cmp++; if ({rdata, res_out} !== 64'h0) begin n_err++; $display("FAIL idle_data: got %h/%h want 0/0", rdata, res_out); end
    endtask

    task automatic test_alu();
        c_M = 4'h0; c_WB = 2'b10; c_res = 32'h1234; c_rd = 5'd5;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall: got %b want 0", stall); end
        @(posedge clk); #1;
        nop();
        n_cmp++; if (wb_out !== 2'b10) begin n_err++; $display("FAIL alu_wb: got %b want 10", wb_out); end
        n_cmp++; if (res_out !== 32'h1234) begin n_err++; $display("FAIL alu_res: got %h want 1234", res_out); end
        n_cmp++; if (rd_out !== 5'd5) begin n_err++; $display("FAIL alu_rd: got %0d want 5", rd_out); end
        n_cmp++; if (wval !== 32'h1234) begin n_err++; $display("FAIL alu_wval: got %h want 1234", wval); end
    endtask

    task automatic test_store_load();
        int n;
        c_M = 4'h1; c_WB = 2'b00; c_res = 32'h10; c_wd = 32'hDEADBEEF; c_rd = 5'd0;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL st_stall1: got %b want 1", stall); end
        @(posedge clk); #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL st_stall2: got %b want 1", stall); end
        n_cmp++; if (wb_out !== 2'b00) begin n_err++; $display("FAIL st_bubble_wb: got %b want 00", wb_out); end
        @(posedge clk); #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL st_release: got %b want 0", stall); end
        @(posedge clk); #1;
        nop();
        do_op(4'h2, 2'b11, 32'h10, 32'h0, 5'd9, n);
        n_cmp++; if (n !== 2) begin n_err++; $display("FAIL ld_cycles: got %0d stall cycles want 2", n); end
        n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL ld_rdata: got %h want deadbeef", rdata); end
        n_cmp++; if (wval !== 32'hDEADBEEF) begin n_err++; $display("FAIL ld_wval: got %h want deadbeef", wval); end
        n_cmp++; if (rd_out !== 5'd9) begin n_err++; $display("FAIL ld_rd: got %0d want 9", rd_out); end
        n_cmp++; if (wb_out !== 2'b11) begin n_err++; $display("FAIL ld_wb: got %b want 11", wb_out); end
    endtask

    task automatic test_wrap();
        int n;
        do_op(4'h1, 2'b00, 32'h400, 32'h55, 5'd0, n);
        do_op(4'h2, 2'b11, 32'h0, 32'h0, 5'd3, n);
        n_cmp++; if (rdata !== 32'h55) begin n_err++; $display("FAIL wrap_rdata: got %h want 55", rdata); end
    endtask

    task automatic test_misalign();
        int n;
        do_op(4'h1, 2'b10, 32'h13, 32'hCAFEF00D, 5'd4, n);
        n_cmp++; if (n !== 2) begin n_err++; $display("FAIL mis_cycles: got %0d want 2", n); end
        n_cmp++; if (mis !== 1'b1) begin n_err++; $display("FAIL mis_pulse: got %b want 1", mis); end
        n_cmp++; if (wb_out[1] !== 1'b0) begin n_err++; $display("FAIL mis_regwrite: got %b want 0", wb_out[1]); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL mis_rdata: got %h want 0", rdata); end
        @(posedge clk); #1;
        n_cmp++; if (mis !== 1'b0) begin n_err++; $display("FAIL mis_width: got %b want 0", mis); end
        do_op(4'h2, 2'b11, 32'h10, 32'h0, 5'd6, n);
        n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL mis_nowrite: got %h want deadbeef", rdata); end
        n_cmp++; if (mis !== 1'b0) begin n_err++; $display("FAIL mis_aligned_ld: got %b want 0", mis); end
    endtask

    task automatic test_read_write_both();
        int n;
        do_op(4'h3, 2'b01, 32'h20, 32'h77, 5'd2, n);
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL both_rdata: got %h want 0", rdata); end
        do_op(4'h2, 2'b11, 32'h20, 32'h0, 5'd2, n);
        n_cmp++; if (rdata !== 32'h77) begin n_err++; $display("FAIL both_commit: got %h want 77", rdata); end
    endtask

    task automatic test_reset_access();
        int n;
        c_M = 4'h1; c_WB = 2'b00; c_res = 32'h30; c_wd = 32'h0000ABCD; c_rd = 5'd0;
        #1;
        @(posedge clk); #1;
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rsta_stall2: got %b want 1", stall); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rsta_stall: got %b want 0", stall); end
        n_cmp++; if ({wb_out, rdata, res_out} !== 66'h0) begin n_err++; $display("FAIL rsta_outs: got %b/%h/%h want 0", wb_out, rdata, res_out); end
        nop();
        rst = 1'b1;
        @(posedge clk); #1;
        do_op(4'h2, 2'b11, 32'h30, 32'h0, 5'd1, n);
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rsta_aborted: got %h want 0", rdata); end
        do_op(4'h2, 2'b11, 32'h10, 32'h0, 5'd1, n);
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rsta_memclr: got %h want 0", rdata); end
    endtask

    task automatic test_back_to_back();
        z_M = 4'h1; z_WB = 2'b00; z_res = 32'h8; z_wd = 32'h11111111; z_rd = 5'd0;
        #1;
        n_cmp++; if (z_stall !== 1'b0) begin n_err++; $display("FAIL ws0_st_stall: got %b want 0", z_stall); end
        @(posedge clk); #1;
        z_M = 4'h2; z_WB = 2'b11; z_res = 32'h8; z_wd = 32'h0; z_rd = 5'd7;
        #1;
        n_cmp++; if (z_stall !== 1'b0) begin n_err++; $display("FAIL ws0_ld_stall: got %b want 0", z_stall); end
        @(posedge clk); #1;
        z_M = 4'h0; z_WB = 2'b00; z_res = 32'h0; z_rd = 5'd0;
        n_cmp++; if (z_rdata !== 32'h11111111) begin n_err++; $display("FAIL ws0_rdata: got %h want 11111111", z_rdata); end
        n_cmp++; if (z_wval !== 32'h11111111) begin n_err++; $display("FAIL ws0_wval: got %h want 11111111", z_wval); end
        n_cmp++; if (z_rd_out !== 5'd7) begin n_err++; $display("FAIL ws0_rd: got %0d want 7", z_rd_out); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_load();
        test_wrap();
        test_misalign();
        test_read_write_both();
        test_reset_access();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
